// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard scoreboard bus: decoded instruction fields in,
// registered stall and bypass selects out.
// master = decode stage driving the instruction, slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 2
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic             valid_i;
  logic [REG_W-1:0] rs1_i;
  logic [REG_W-1:0] rs2_i;
  logic             use_rs1_i;
  logic             use_rs2_i;
  logic [REG_W-1:0] rd_i;
  logic             is_load_i;
  logic             branch_i;
  logic             stall_out;
  logic [SEL_W-1:0] fwd_rs1_o;
  logic [SEL_W-1:0] fwd_rs2_o;

  modport master (
    output valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, is_load_i, branch_i,
    input  stall_out, fwd_rs1_o, fwd_rs2_o
  );

  modport slave (
    input  valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, is_load_i, branch_i,
    output stall_out, fwd_rs1_o, fwd_rs2_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage data/control hazard unit.
// Compares decoded sources against a DEPTH-deep history of in-flight
// destinations (slot 1 = youngest) and issues stall cycles; a branch that
// issues is followed by BRANCH_STALLS stall cycles. All state moves on the
// falling edge of clk so outputs are stable for the next rising edge.
// Optional feature macro: HAZARD_BYPASS_EN -- only load-use at slot 1 stalls,
// every other match is reported as a bypass slot on fwd_rs1_o/fwd_rs2_o.
module hazard_scoreboard #(
  parameter int REG_W         = 5,
  parameter int DEPTH         = 2,
  parameter int BRANCH_STALLS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_scoreboard_if.slave   bus
);
  localparam int MAXC  = (DEPTH > BRANCH_STALLS) ? DEPTH : BRANCH_STALLS;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [REG_W-1:0] hist_rd_q [1:DEPTH];
  logic [REG_W-1:0] hist_rd_d [1:DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic [SEL_W-1:0] fwd1_q, fwd1_d;
  logic [SEL_W-1:0] fwd2_q, fwd2_d;
  logic [SEL_W-1:0] k1_s, k2_s;
  logic [CNT_W-1:0] needed_s;
  logic             ld_new_s;

`ifdef HAZARD_BYPASS_EN
  logic             hist_ld_q [1:DEPTH];
  logic             hist_ld_d [1:DEPTH];
`else
  logic [SEL_W-1:0] kmin_s;
  logic             unused_load_s;
  assign unused_load_s = bus.is_load_i;
`endif

  // Smallest matching history slot per source; x0 and unread sources never match.
  always_comb begin
    k1_s = {SEL_W{1'b0}};
    k2_s = {SEL_W{1'b0}};
    for (int k = DEPTH; k >= 1; k--) begin
      k1_s = (bus.use_rs1_i && (hist_rd_q[k] != {REG_W{1'b0}}) && (hist_rd_q[k] == bus.rs1_i))
             ? SEL_W'(k) : k1_s;
      k2_s = (bus.use_rs2_i && (hist_rd_q[k] != {REG_W{1'b0}}) && (hist_rd_q[k] == bus.rs2_i))
             ? SEL_W'(k) : k2_s;
    end
  end

`ifdef HAZARD_BYPASS_EN
  // Only a load result one slot back cannot be bypassed: one stall cycle.
  always_comb begin
    if (((k1_s == SEL_W'(1)) || (k2_s == SEL_W'(1))) && hist_ld_q[1]) begin
      needed_s = CNT_W'(1);
    end else begin
      needed_s = {CNT_W{1'b0}};
    end
    ld_new_s = bus.is_load_i;
  end
`else
  // Full-stall mode: wait until the youngest producer has left the window.
  always_comb begin
    if (k1_s == {SEL_W{1'b0}}) begin
      kmin_s = k2_s;
    end else if ((k2_s == {SEL_W{1'b0}}) || (k1_s < k2_s)) begin
      kmin_s = k1_s;
    end else begin
      kmin_s = k2_s;
    end
    if (kmin_s == {SEL_W{1'b0}}) begin
      needed_s = {CNT_W{1'b0}};
    end else begin
      needed_s = CNT_W'(DEPTH + 1 - int'(kmin_s));
    end
    ld_new_s = 1'b0;
  end
`endif

  // Next-state: pending stalls first, then new hazards, then issue or idle.
  always_comb begin
    for (int k = 2; k <= DEPTH; k++) begin
      hist_rd_d[k] = hist_rd_q[k-1];
    end
    hist_rd_d[1] = {REG_W{1'b0}};
`ifdef HAZARD_BYPASS_EN
    for (int k = 2; k <= DEPTH; k++) begin
      hist_ld_d[k] = hist_ld_q[k-1];
    end
    hist_ld_d[1] = 1'b0;
`endif
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    fwd1_d  = {SEL_W{1'b0}};
    fwd2_d  = {SEL_W{1'b0}};
    if (cnt_q != {CNT_W{1'b0}}) begin
      stall_d = 1'b1;
      cnt_d   = cnt_q - CNT_W'(1);
    end else if (bus.valid_i && (needed_s != {CNT_W{1'b0}})) begin
      stall_d = 1'b1;
      cnt_d   = needed_s - CNT_W'(1);
    end else if (bus.valid_i) begin
      hist_rd_d[1] = bus.rd_i;
`ifdef HAZARD_BYPASS_EN
      hist_ld_d[1] = ld_new_s;
      fwd1_d       = k1_s;
      fwd2_d       = k2_s;
`endif
      cnt_d = bus.branch_i ? CNT_W'(BRANCH_STALLS) : {CNT_W{1'b0}};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State and registered outputs, synchronous active-low reset on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        hist_rd_q[k] <= {REG_W{1'b0}};
`ifdef HAZARD_BYPASS_EN
        hist_ld_q[k] <= 1'b0;
`endif
      end
      cnt_q   <= {CNT_W{1'b0}};
      stall_q <= 1'b0;
      fwd1_q  <= {SEL_W{1'b0}};
      fwd2_q  <= {SEL_W{1'b0}};
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        hist_rd_q[k] <= hist_rd_d[k];
`ifdef HAZARD_BYPASS_EN
        hist_ld_q[k] <= hist_ld_d[k];
`endif
      end
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
    end
  end

  assign bus.stall_out = stall_q;
  assign bus.fwd_rs1_o = fwd1_q;
  assign bus.fwd_rs2_o = fwd2_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (DEPTH=2, BRANCH_STALLS=2).
// One table row = one falling edge: inputs presented before the edge and the
// outputs required just after it. Expected values go through a queue.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(5), .DEPTH(2)) bus ();

  hazard_scoreboard #(.REG_W(5), .DEPTH(2), .BRANCH_STALLS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [4:0] rs1;
    logic       use1;
    logic [4:0] rs2;
    logic       use2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       stall;
    logic [1:0] f1;
    logic [1:0] f2;
  } vec_t;

  typedef struct {
    logic       stall;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic r, logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                              logic u2, logic [4:0] rd, logic ld, logic br,
                              logic st, logic [1:0] f1, logic [1:0] f2);
    vec_t x;
    x.rst_n = r; x.valid = v; x.rs1 = rs1; x.use1 = u1; x.rs2 = rs2; x.use2 = u2;
    x.rd = rd; x.ld = ld; x.br = br; x.stall = st; x.f1 = f1; x.f2 = f2;
    return x;
  endfunction

  task automatic drive(vec_t v);
    rst_n         = v.rst_n;
    bus.valid_i   = v.valid;
    bus.rs1_i     = v.rs1;
    bus.use_rs1_i = v.use1;
    bus.rs2_i     = v.rs2;
    bus.use_rs2_i = v.use2;
    bus.rd_i      = v.rd;
    bus.is_load_i = v.ld;
    bus.branch_i  = v.br;
  endtask

  task automatic apply(vec_t v, int idx);
    exp_t e;
    exp_t x;
    @(posedge clk); #1;
    drive(v);
    x.stall = v.stall; x.f1 = v.f1; x.f2 = v.f2;
    exp_q.push_back(x);
    @(negedge clk); #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL row%0d: expected queue empty", idx);
    end else begin
      e = exp_q.pop_front();
      if ({bus.stall_out, bus.fwd_rs1_o, bus.fwd_rs2_o} !== {e.stall, e.f1, e.f2}) begin
        bad++;
        $display("FAIL row%0d: got stall=%0b fwd1=%0d fwd2=%0d, want stall=%0b fwd1=%0d fwd2=%0d",
                 idx, bus.stall_out, bus.fwd_rs1_o, bus.fwd_rs2_o, e.stall, e.f1, e.f2);
      end
    end
  endtask

  // Issue a producer, then hold a consumer and count the stall edges before it issues.
  task automatic count_seq(string nm, logic [4:0] prd, logic pld, logic pbr,
                           logic [4:0] crs1, int want);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    @(posedge clk); #1;
    drive(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, prd, pld, pbr, 1'b0, 2'd0, 2'd0));
    @(posedge clk); #1;
    drive(mk(1'b1, 1'b1, crs1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (bus.stall_out === 1'b1) begin
        n++;
      end else begin
        done = 1'b1;
        break;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s: stall never released after %0d edges, want %0d stalls", nm, n, want);
    end else if (n != want) begin
      bad++;
      $display("FAIL %s: got %0d stalls, want %0d", nm, n, want);
    end
    @(posedge clk); #1;
    drive(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
  endtask

  initial begin
    drive(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
`ifdef HAZARD_BYPASS_EN
    //              rst   vld   rs1  u1    rs2  u2    rd   ld    br    stall f1    f2
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
`else
    //              rst   vld   rs1  u1    rs2  u2    rd   ld    br    stall f1    f2
    // reset held while a hazard is presented, then an empty history
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    // slot-1 hazard: 2 stalls then issue
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    // slot-2 hazard on rs2: 1 stall
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    // x0 and unused sources never stall
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    // branch without hazard: 2 stalls, held instruction then issues
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    // branch with data hazard: 2 data stalls, issue, 2 branch stalls
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    // reset during the 2nd branch stall, then immediate issue
    tbl.push_back(mk(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
    tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
    tbl.push_back(mk(1'b1, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0));
`endif
    foreach (tbl[i]) begin
      apply(tbl[i], i);
    end

`ifdef HAZARD_BYPASS_EN
    count_seq("load_use_stalls", 5'd12, 1'b1, 1'b0, 5'd12, 1);
    count_seq("alu_bypass_stalls", 5'd13, 1'b0, 1'b0, 5'd13, 0);
`else
    count_seq("slot1_stalls", 5'd12, 1'b0, 1'b0, 5'd12, 2);
`endif
    count_seq("branch_stalls", 5'd0, 1'b0, 1'b1, 5'd20, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
